// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: decodes memory-mapped debug writes into trace channels,
// timestamps them, queues them in a FIFO and drains them over a valid/ready
// record stream. Includes drain-before-halt, a channel mask and a saturating
// drop counter.
module debug_trace_buffer #(
    parameter logic [15:0] ADDRESS    = 16'h0000,
    parameter int          N_CHANNELS = 8,
    parameter int          DEPTH      = 16,
    parameter int          TICK_W     = 64,
    parameter int          CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       we_i,
    input  logic [23:0]                addr_i,
    input  logic [31:0]                data_i,
    input  logic [63:0]                tick_cntr_i,
    output logic                       rec_valid_o,
    input  logic                       rec_ready_i,
    output logic [CH_W-1:0]            rec_chan_o,
    output logic [31:0]                rec_data_o,
    output logic [TICK_W-1:0]          rec_tick_o,
    output logic [15:0]                rec_src_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic [15:0]                drop_cnt_o,
    output logic                       halt_o
);

    localparam int         LVL_W  = $clog2(DEPTH + 1);
    localparam int         PTR_W  = $clog2(DEPTH);
    localparam logic [6:0] N_CH_L = 7'(N_CHANNELS);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e                  state_r;
    state_e                  state_next_s;
    logic                    halt_r;
    logic                    halt_next_s;
    logic [N_CHANNELS-1:0]   mask_r;
    logic [15:0]             drop_cnt_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic [CH_W-1:0]         chan_mem_r [DEPTH];
    logic [31:0]             data_mem_r [DEPTH];
    logic [TICK_W-1:0]       tick_mem_r [DEPTH];

    logic                    wr_s;
    logic                    halt_wr_s;
    logic                    mask_wr_s;
    logic                    clr_wr_s;
    logic                    trace_wr_s;
    logic [5:0]              chan_idx_s;
    logic [63:0]             mask_ext_s;
    logic                    mask_bit_s;
    logic                    in_run_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;

    // Address decode of the debug write port and channel mask lookup
    always_comb begin
        wr_s       = en_i & we_i;
        halt_wr_s  = wr_s && (addr_i == 24'h000004);
        mask_wr_s  = wr_s && (addr_i == 24'h000008);
        clr_wr_s   = wr_s && (addr_i == 24'h00000C);
        chan_idx_s = addr_i[7:2];
        trace_wr_s = wr_s && (addr_i[23:8] == 16'h0001) && (addr_i[1:0] == 2'b00)
                     && ({1'b0, chan_idx_s} < N_CH_L);
        mask_ext_s = 64'd0;
        mask_ext_s[N_CHANNELS-1:0] = mask_r;
        mask_bit_s = mask_ext_s[chan_idx_s];
    end

    // Push/pop/drop arbitration; a full FIFO still accepts when a pop frees a slot
    always_comb begin
        in_run_s = (state_r == ST_RUN);
        full_s   = (level_r == LVL_W'(DEPTH));
        pop_s    = (level_r != {LVL_W{1'b0}}) && rec_ready_i;
        if (trace_wr_s && in_run_s && mask_bit_s) begin
            push_s = !full_s || pop_s;
            drop_s = full_s && !pop_s;
        end else if (trace_wr_s && !in_run_s) begin
            push_s = 1'b0;
            drop_s = 1'b1;
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Runtime channel mask; all channels enabled out of reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mask_r <= {N_CHANNELS{1'b1}};
        end else if (mask_wr_s) begin
            mask_r <= data_i[N_CHANNELS-1:0];
        end
    end

    // Saturating drop counter with explicit clear
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            drop_cnt_r <= 16'd0;
        end else if (clr_wr_s) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Record storage; contents are don't-care until written so no reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            chan_mem_r[wr_ptr_r] <= chan_idx_s[CH_W-1:0];
            data_mem_r[wr_ptr_r] <= data_i;
            tick_mem_r[wr_ptr_r] <= tick_cntr_i[TICK_W-1:0];
        end
    end

    // Halt sequencer state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Halt sequencer next state: RUN -> DRAIN on halt write, DRAIN -> HALTED once empty
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (halt_wr_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (level_r == {LVL_W{1'b0}}) begin
                    state_next_s = ST_HALTED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALTED: state_next_s = ST_HALTED;
            default:   state_next_s = ST_RUN;
        endcase
    end

    // Halt sequencer output decode, registered so halt_o is glitch-free
    always_comb begin
        halt_next_s = (state_next_s == ST_HALTED);
    end

    // Registered halt request, sticky until reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            halt_r <= 1'b0;
        end else begin
            halt_r <= halt_next_s;
        end
    end

    assign rec_valid_o = (level_r != {LVL_W{1'b0}});
    assign rec_chan_o  = chan_mem_r[rd_ptr_r];
    assign rec_data_o  = data_mem_r[rd_ptr_r];
    assign rec_tick_o  = tick_mem_r[rd_ptr_r];
    assign rec_src_o   = ADDRESS;
    assign level_o     = level_r;
    assign drop_cnt_o  = drop_cnt_r;
    assign halt_o      = halt_r;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Self-checking bench for debug_trace_buffer: directed scenarios plus a
// randomized run, checked against a queue-based reference model.
module tb_debug_trace_buffer;

    localparam int N_CH  = 8;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [5:0]  chan;
        logic [31:0] data;
        logic [63:0] tick;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        we;
    logic [23:0] addr;
    logic [31:0] data;
    logic [63:0] tick;
    logic        rdy;
    logic        rec_valid_o;
    logic [2:0]  rec_chan_o;
    logic [31:0] rec_data_o;
    logic [63:0] rec_tick_o;
    logic [15:0] rec_src_o;
    logic [4:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        halt_o;

    // reference model state
    rec_t        mdl_q[$];
    rec_t        exp_pops[$];
    rec_t        dut_pops[$];
    int          m_state;   // 0 run, 1 drain, 2 halted
    logic [N_CH-1:0] m_mask;
    int          m_drop;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    debug_trace_buffer #(
        .ADDRESS(16'h0000), .N_CHANNELS(N_CH), .DEPTH(DEPTH), .TICK_W(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .we_i(we), .addr_i(addr),
        .data_i(data), .tick_cntr_i(tick), .rec_valid_o(rec_valid_o),
        .rec_ready_i(rdy), .rec_chan_o(rec_chan_o), .rec_data_o(rec_data_o),
        .rec_tick_o(rec_tick_o), .rec_src_o(rec_src_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .halt_o(halt_o)
    );

    task automatic model_drop();
        if (m_drop < 65535) m_drop = m_drop + 1;
    endtask

    // Reference model: one call per rising edge, using the inputs held over it
    task automatic model_step();
        int   size_pre;
        int   st_pre;
        int   ai;
        int   k;
        bit   pop;
        bit   push;
        rec_t r;
        if (!rst_n) begin
            mdl_q.delete();
            m_mask  = '1;
            m_drop  = 0;
            m_state = 0;
            return;
        end
        size_pre = mdl_q.size();
        st_pre   = m_state;
        pop      = (size_pre > 0) && rdy;
        push     = 1'b0;
        r        = '0;
        ai       = int'(addr);
        if (en && we) begin
            if (ai == 4) begin
                if (st_pre == 0) m_state = 1;
            end else if (ai == 8) begin
                m_mask = data[N_CH-1:0];
            end else if (ai == 12) begin
                m_drop = 0;
            end else if (ai >= 256 && ai < 256 + 4 * N_CH && (ai % 4) == 0) begin
                k = (ai - 256) / 4;
                if (st_pre != 0) begin
                    model_drop();
                end else if (m_mask[k]) begin
                    if (size_pre < DEPTH || pop) begin
                        push   = 1'b1;
                        r.chan = 6'(k);
                        r.data = data;
                        r.tick = tick;
                    end else begin
                        model_drop();
                    end
                end
            end
        end
        if (pop) exp_pops.push_back(mdl_q.pop_front());
        if (push) mdl_q.push_back(r);
        if (st_pre == 1 && size_pre == 0) m_state = 2;
    endtask

    // One clock cycle: drive inputs, log the DUT pop, step the model at the edge
    task automatic cycle(input bit r, input bit e, input bit w, input logic [23:0] a,
                         input logic [31:0] d, input bit rd);
        rec_t p;
        rst_n = r; en = e; we = w; addr = a; data = d; rdy = rd;
        @(negedge clk);
        if (r && rec_valid_o && rdy) begin
            p.chan = 6'(rec_chan_o);
            p.data = rec_data_o;
            p.tick = rec_tick_o;
            dut_pops.push_back(p);
        end
        @(posedge clk);
        model_step();
        #1;
        tick = tick + 64'd1;
    endtask

    task automatic wr(input logic [23:0] a, input logic [31:0] d, input bit rd);
        cycle(1'b1, 1'b1, 1'b1, a, d, rd);
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 24'h0, 32'h0, rd);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 24'h000100, 32'h1, 1'b0);
        total++; if (level_o !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level_o); end
        total++; if (rec_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rec_valid_o); end
        total++; if (drop_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o); end
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL reset_halt got=%0b exp=0", halt_o); end
        total++; if (rec_src_o !== 16'h0000) begin bad++; $display("FAIL src got=%h exp=0000", rec_src_o); end
    endtask

    task automatic test_ordered();
        logic [23:0] a_t[3];
        logic [31:0] d_t[3];
        logic [2:0]  c_t[3];
        a_t = '{24'h000100, 24'h00010C, 24'h00011C};
        d_t = '{32'hA, 32'hB, 32'hC};
        c_t = '{3'd0, 3'd3, 3'd7};
        tick = 64'd10;
        for (int i = 0; i < 3; i++) begin
            wr(a_t[i], d_t[i], 1'b1);
            total++;
            if (rec_valid_o !== 1'b1 || rec_chan_o !== c_t[i] || rec_data_o !== d_t[i]
                || rec_tick_o !== 64'(10 + i) || level_o !== 5'd1) begin
                bad++;
                $display("FAIL ordered_%0d got v=%0b ch=%0d d=%h t=%0d lvl=%0d exp v=1 ch=%0d d=%h t=%0d lvl=1",
                         i, rec_valid_o, rec_chan_o, rec_data_o, rec_tick_o, level_o, c_t[i], d_t[i], 10 + i);
            end
        end
        idle(2, 1'b1);
        total++;
        if (dut_pops.size() != 3 || level_o !== 5'd0) begin
            bad++; $display("FAIL ordered_pops got=%0d lvl=%0d exp=3 lvl=0", dut_pops.size(), level_o);
        end
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] ov_data[21];
        for (int i = 0; i < 20; i++) begin
            ov_data[i] = $urandom;
            wr(24'h000104, ov_data[i], 1'b0);
        end
        total++; if (level_o !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", level_o); end
        total++; if (drop_cnt_o !== 16'd4) begin bad++; $display("FAIL ovf_drop got=%0d exp=4", drop_cnt_o); end
        ov_data[20] = $urandom;
        wr(24'h000104, ov_data[20], 1'b1);
        total++; if (level_o !== 5'd16) begin bad++; $display("FAIL full_pop_push_level got=%0d exp=16", level_o); end
        total++; if (drop_cnt_o !== 16'd4) begin bad++; $display("FAIL full_pop_push_drop got=%0d exp=4", drop_cnt_o); end
        for (int i = 0; i < 40 && level_o != 5'd0; i++) idle(1, 1'b1);
        total++;
        if (dut_pops.size() != 17) begin
            bad++; $display("FAIL ovf_pop_count got=%0d exp=17", dut_pops.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                total++;
                if (dut_pops[i].chan !== 6'd1 || dut_pops[i].data !== ov_data[(i < 16) ? i : 20]) begin
                    bad++; $display("FAIL ovf_rec_%0d got ch=%0d d=%h exp ch=1 d=%h",
                                    i, dut_pops[i].chan, dut_pops[i].data, ov_data[(i < 16) ? i : 20]);
                end
            end
        end
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_mask();
        wr(24'h000008, 32'h01, 1'b1);
        wr(24'h000100, 32'h11, 1'b1);
        wr(24'h000108, 32'h22, 1'b1);
        idle(3, 1'b1);
        total++;
        if (dut_pops.size() != 1) begin
            bad++; $display("FAIL mask_count got=%0d exp=1", dut_pops.size());
        end else if (dut_pops[0].chan !== 6'd0 || dut_pops[0].data !== 32'h11) begin
            bad++; $display("FAIL mask_rec got ch=%0d d=%h exp ch=0 d=11", dut_pops[0].chan, dut_pops[0].data);
        end
        total++; if (drop_cnt_o !== 16'd4) begin bad++; $display("FAIL mask_drop got=%0d exp=4", drop_cnt_o); end
        wr(24'h00000C, 32'h0, 1'b1);
        total++; if (drop_cnt_o !== 16'd0) begin bad++; $display("FAIL clear got=%0d exp=0", drop_cnt_o); end
        wr(24'h000008, 32'hFF, 1'b1);
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_decode();
        wr(24'h000120, 32'h1, 1'b0);
        wr(24'h000102, 32'h2, 1'b0);
        wr(24'h000050, 32'h3, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 24'h000100, 32'h4, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 24'h000004, 32'h5, 1'b0);
        total++;
        if (level_o !== 5'd0 || drop_cnt_o !== 16'd0 || halt_o !== 1'b0 || rec_valid_o !== 1'b0) begin
            bad++; $display("FAIL decode got lvl=%0d drop=%0d halt=%0b exp 0 0 0", level_o, drop_cnt_o, halt_o);
        end
        wr(24'h000108, 32'h6, 1'b0);
        total++; if (level_o !== 5'd1) begin bad++; $display("FAIL decode_run got=%0d exp=1", level_o); end
        idle(2, 1'b1);
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_random();
        int op;
        bit rd;
        for (int c = 0; c < 400; c++) begin
            op = $urandom_range(0, 9);
            rd = ($urandom_range(0, 2) == 0);
            case (op)
                6:       wr(24'h000008, $urandom, rd);
                7:       wr(24'h00000C, 32'h0, rd);
                8:       wr(24'(256 + 4 * N_CH + 4 * $urandom_range(0, 7) + (c % 2)), $urandom, rd);
                9:       idle(1, rd);
                default: wr(24'(256 + 4 * $urandom_range(0, N_CH - 1)), $urandom, rd);
            endcase
            total++;
            if (level_o !== 5'(mdl_q.size()) || drop_cnt_o !== 16'(m_drop)) begin
                bad++; $display("FAIL rand_state c=%0d got lvl=%0d drop=%0d exp lvl=%0d drop=%0d",
                                c, level_o, drop_cnt_o, mdl_q.size(), m_drop);
            end
        end
        wr(24'h000008, 32'hFF, 1'b1);
        for (int i = 0; i < 40 && level_o != 5'd0; i++) idle(1, 1'b1);
        total++;
        if (dut_pops.size() != exp_pops.size() || dut_pops.size() == 0) begin
            bad++; $display("FAIL rand_pop_count got=%0d exp=%0d", dut_pops.size(), exp_pops.size());
        end else begin
            for (int i = 0; i < exp_pops.size(); i++) begin
                total++;
                if (dut_pops[i] !== exp_pops[i]) begin
                    bad++; $display("FAIL rand_rec_%0d got=%h exp=%h", i, dut_pops[i], exp_pops[i]);
                end
            end
        end
        wr(24'h00000C, 32'h0, 1'b1);
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_drain_halt();
        int drop0;
        int rise_at;
        for (int i = 0; i < 5; i++) wr(24'h000108, 32'(100 + i), 1'b0);
        drop0 = int'(drop_cnt_o);
        wr(24'h000004, 32'h0, 1'b0);
        wr(24'h000100, 32'h55, 1'b0);
        total++; if (int'(drop_cnt_o) != drop0 + 1) begin bad++; $display("FAIL drain_drop got=%0d exp=%0d", drop_cnt_o, drop0 + 1); end
        total++; if (level_o !== 5'd5 || halt_o !== 1'b0) begin bad++; $display("FAIL drain_hold got lvl=%0d halt=%0b exp 5 0", level_o, halt_o); end
        rise_at = -1;
        for (int i = 1; i <= 20 && rise_at < 0; i++) begin
            idle(1, 1'b1);
            total++;
            if (halt_o !== (m_state == 2)) begin
                bad++; $display("FAIL drain_halt_cyc%0d got=%0b exp=%0b", i, halt_o, m_state == 2);
            end
            if (halt_o === 1'b1) rise_at = i;
        end
        total++; if (rise_at != 6) begin bad++; $display("FAIL halt_timing got=%0d exp=6", rise_at); end
        total++; if (dut_pops.size() != 5) begin bad++; $display("FAIL drain_pops got=%0d exp=5", dut_pops.size()); end
        drop0 = int'(drop_cnt_o);
        wr(24'h000004, 32'h0, 1'b1);
        wr(24'h000104, 32'h66, 1'b1);
        total++;
        if (halt_o !== 1'b1 || level_o !== 5'd0 || int'(drop_cnt_o) != drop0 + 1) begin
            bad++; $display("FAIL halted got halt=%0b lvl=%0d drop=%0d exp 1 0 %0d", halt_o, level_o, drop_cnt_o, drop0 + 1);
        end
        dut_pops.delete(); exp_pops.delete();
    endtask

    task automatic test_reset_mid();
        cycle(1'b0, 1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
        for (int i = 0; i < 8; i++) wr(24'h000110, $urandom, 1'b0);
        wr(24'h000004, 32'h0, 1'b0);
        wr(24'h000100, 32'h1, 1'b0);
        total++; if (level_o !== 5'd8 || drop_cnt_o !== 16'd1) begin bad++; $display("FAIL pre_reset got lvl=%0d drop=%0d exp 8 1", level_o, drop_cnt_o); end
        cycle(1'b0, 1'b1, 1'b1, 24'h000104, 32'h9, 1'b1);
        total++;
        if (level_o !== 5'd0 || rec_valid_o !== 1'b0 || halt_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            bad++; $display("FAIL mid_reset got lvl=%0d v=%0b halt=%0b drop=%0d exp 0 0 0 0",
                            level_o, rec_valid_o, halt_o, drop_cnt_o);
        end
        wr(24'h00011C, 32'h77, 1'b0);
        wr(24'h00010C, 32'h78, 1'b0);
        total++; if (level_o !== 5'd2) begin bad++; $display("FAIL post_reset_mask got=%0d exp=2", level_o); end
        idle(4, 1'b1);
        total++;
        if (dut_pops.size() != 2 || exp_pops.size() != 2) begin
            bad++; $display("FAIL post_reset_pops got=%0d exp=2", dut_pops.size());
        end else if (dut_pops[0].data !== 32'h77 || dut_pops[0].chan !== 6'd7 || dut_pops[1] !== exp_pops[1]) begin
            bad++; $display("FAIL post_reset_rec got=%h exp ch=7 d=77", dut_pops[0]);
        end
        total++; if (halt_o !== 1'b0) begin bad++; $display("FAIL post_reset_run got=%0b exp=0", halt_o); end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = 24'h0; data = 32'h0; rdy = 1'b0;
        tick = 64'h0123_4567_0000_0000;
        m_state = 0; m_mask = '1; m_drop = 0;
        @(posedge clk); #1;
        test_reset();
        test_ordered();
        test_overflow();
        test_mask();
        test_decode();
        test_random();
        test_drain_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
